// File: rtl/pwm_ramp_ctrl.sv
// Duty sequencer in front of the PWM output stage: accepts target-duty commands,
// ramps the live duty toward them on period boundaries and emits the period tick.
module pwm_ramp_ctrl #(
   parameter int DUTY_W           = 6,
   parameter int PERIOD           = 64,
   parameter int STEP             = 1,
   parameter int PERIODS_PER_STEP = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DUTY_W-1:0] cmd_duty,
   input  logic              cmd_instant,
   input  logic              abort,
   output logic [DUTY_W-1:0] duty_out,
   output logic              period_tick,
   output logic              busy,
   output logic              done
);

   // state     | meaning
   // IDLE      | holding duty, after reset or abort; accepts commands
   // RAMP_UP   | stepping duty upward toward target on period boundaries
   // RAMP_DOWN | stepping duty downward toward target on period boundaries
   // HOLD      | target reached; holding duty; accepts commands
   typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN, HOLD} state_t;

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int SW = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(PERIODS_PER_STEP - 1);
   // Steps larger than the full duty range behave like a jump, so clamp the constant.
   localparam logic [DUTY_W:0] STEP_W = (STEP >= (1 << DUTY_W)) ?
                                        (DUTY_W+1)'(1 << DUTY_W) : (DUTY_W+1)'(STEP);

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [SW-1:0]     step_cnt;
   logic [DUTY_W-1:0] target;
   logic              instant;

   logic [DUTY_W:0]   gap;
   logic [DUTY_W:0]   delta;
   logic [DUTY_W:0]   duty_wide;
   logic [DUTY_W-1:0] duty_step;

   assign period_tick = enable && (cnt == CNT_LAST);
   assign busy        = (state == RAMP_UP) || (state == RAMP_DOWN);
   assign cmd_ready   = ((state == IDLE) || (state == HOLD)) && !abort;

   // One-bit-wider arithmetic so a step can never wrap past 0 or full scale.
   always_comb begin
      gap       = '0;
      delta     = '0;
      duty_wide = {1'b0, duty_out};
      if (state == RAMP_UP) gap = {1'b0, target} - {1'b0, duty_out};
      else                  gap = {1'b0, duty_out} - {1'b0, target};
      delta = (gap < STEP_W) ? gap : STEP_W;
      if (state == RAMP_UP) duty_wide = {1'b0, duty_out} + delta;
      else                  duty_wide = {1'b0, duty_out} - delta;
      duty_step = duty_wide[DUTY_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         step_cnt <= '0;
         target   <= '0;
         instant  <= 1'b0;
         duty_out <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (enable) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

         if (abort) begin
            state    <= IDLE;
            step_cnt <= '0;
         end else if (cmd_valid && cmd_ready) begin
            target   <= cmd_duty;
            instant  <= cmd_instant;
            step_cnt <= '0;
            if (cmd_duty > duty_out)      state <= RAMP_UP;
            else if (cmd_duty < duty_out) state <= RAMP_DOWN;
            else begin
               state <= HOLD;
               done  <= 1'b1;
            end
         end else if (busy && period_tick) begin
            if (instant) begin
               duty_out <= target;
               state    <= HOLD;
               done     <= 1'b1;
            end else if (step_cnt == STEP_LAST) begin
               step_cnt <= '0;
               duty_out <= duty_step;
               if (duty_step == target) begin
                  state <= HOLD;
                  done  <= 1'b1;
               end
            end else begin
               step_cnt <= step_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: a directed table, an abort-at-boundary sequence and random
// traffic, checked every cycle against a tick-counting reference model (STEP=1 and STEP=2).
module tb_pwm_ramp_ctrl;

   localparam int PERIOD = 64;
   localparam int PPS    = 4;
   localparam int ND     = 2;

   logic       clk = 1'b0;
   logic       reset, enable, cmd_valid, cmd_instant, abort;
   logic [5:0] cmd_duty;

   logic [ND-1:0] ready_o, tick_o, busy_o, done_o;
   logic [5:0]    duty_o [ND];

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   // Reference model: mode 0 idle, 1 ramping, 2 hold; ticks counts boundaries since the command.
   int m_step [ND] = '{1, 2};
   int m_pos  [ND];
   int m_duty [ND];
   int m_tgt  [ND];
   int m_mode [ND];
   int m_ticks[ND];
   bit m_inst [ND];
   bit m_done [ND];

   always #5 clk = ~clk;

   pwm_ramp_ctrl #(.DUTY_W(6), .PERIOD(PERIOD), .STEP(1), .PERIODS_PER_STEP(PPS)) u_dut0 (
      .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(ready_o[0]),
      .cmd_duty(cmd_duty), .cmd_instant(cmd_instant), .abort(abort), .duty_out(duty_o[0]),
      .period_tick(tick_o[0]), .busy(busy_o[0]), .done(done_o[0]));

   pwm_ramp_ctrl #(.DUTY_W(6), .PERIOD(PERIOD), .STEP(2), .PERIODS_PER_STEP(PPS)) u_dut1 (
      .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(ready_o[1]),
      .cmd_duty(cmd_duty), .cmd_instant(cmd_instant), .abort(abort), .duty_out(duty_o[1]),
      .period_tick(tick_o[1]), .busy(busy_o[1]), .done(done_o[1]));

   task automatic chk(input string name, input int dut, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d actual %0d required %0d at %0t", name, dut, act, exp, $time);
      end
   endtask

   task automatic model_step(input int i);
      bit tick, rdy, nd;
      int diff, mag;
      if (reset) begin
         m_pos[i] = 0; m_duty[i] = 0; m_tgt[i] = 0; m_mode[i] = 0;
         m_ticks[i] = 0; m_inst[i] = 1'b0; m_done[i] = 1'b0;
      end else begin
         tick = enable && (m_pos[i] == PERIOD - 1);
         rdy  = (m_mode[i] != 1) && !abort;
         nd   = 1'b0;
         if (abort) begin
            m_mode[i]  = 0;
            m_ticks[i] = 0;
         end else if (cmd_valid && rdy) begin
            m_tgt[i]   = int'(cmd_duty);
            m_inst[i]  = cmd_instant;
            m_ticks[i] = 0;
            if (m_tgt[i] == m_duty[i]) begin
               m_mode[i] = 2;
               nd = 1'b1;
            end else begin
               m_mode[i] = 1;
            end
         end else if (m_mode[i] == 1 && tick) begin
            m_ticks[i]++;
            if (m_inst[i] || (m_ticks[i] % PPS == 0)) begin
               diff = m_tgt[i] - m_duty[i];
               mag  = (diff < 0) ? -diff : diff;
               if (mag > m_step[i] && !m_inst[i]) mag = m_step[i];
               m_duty[i] = (diff < 0) ? m_duty[i] - mag : m_duty[i] + mag;
               if (m_duty[i] == m_tgt[i]) begin
                  m_mode[i] = 2;
                  nd = 1'b1;
               end
            end
         end
         if (enable) m_pos[i] = (m_pos[i] + 1) % PERIOD;
         m_done[i] = nd;
      end
   endtask

   // Compare at the falling edge, then advance the model with the same inputs the DUT sees.
   task automatic run_cycle();
      @(negedge clk);
      for (int i = 0; i < ND; i++) begin
         if (chk_en) begin
            chk("duty_out",    i, 32'(duty_o[i]), m_duty[i]);
            chk("period_tick", i, 32'(tick_o[i]), 32'(enable && (m_pos[i] == PERIOD - 1)));
            chk("cmd_ready",   i, 32'(ready_o[i]), 32'((m_mode[i] != 1) && !abort));
            chk("busy",        i, 32'(busy_o[i]), 32'(m_mode[i] == 1));
            chk("done",        i, 32'(done_o[i]), 32'(m_done[i]));
         end
         model_step(i);
      end
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit rst, en, valid;
      int cduty;
      bit inst, abrt;
      int ncyc;
      int exp_duty;
      bit exp_busy;
   } vec_t;

   localparam int NV = 13;
   vec_t tbl [NV];
   int   saved;
   int   d;

   initial begin
      //            rst en  vld duty inst abrt ncyc  duty busy
      tbl[0]  = '{1'b1, 1'b1, 1'b0,  0, 1'b0, 1'b0,    2,  0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0,  0, 1'b0, 1'b0,   10,  0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 1'b1,  3, 1'b0, 1'b0, 1100,  3, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b1,  5, 1'b1, 1'b0,   70,  5, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 10, 1'b0, 1'b0,  100,  5, 1'b1};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 20, 1'b0, 1'b1,    1,  5, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b0,  100,  5, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b1,  5, 1'b0, 1'b0,    3,  5, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 40, 1'b1, 1'b0,   70, 40, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b1,  0, 1'b0, 1'b0,   50, 40, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 1'b0,  0, 1'b0, 1'b0,    1,  0, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 1'b1,  3, 1'b0, 1'b0, 1100,  3, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 1'b1,  0, 1'b0, 1'b0, 1100,  0, 1'b0};

      reset = 1'b1; enable = 1'b0; cmd_valid = 1'b0; cmd_instant = 1'b0;
      abort = 1'b0; cmd_duty = '0;

      for (int k = 0; k < NV; k++) begin
         for (int c = 0; c < tbl[k].ncyc; c++) begin
            chk_en      = !(k == 0 && c == 0);
            reset       = tbl[k].rst;
            enable      = tbl[k].en;
            cmd_valid   = tbl[k].valid && (c == 0);
            cmd_duty    = 6'(tbl[k].cduty);
            cmd_instant = tbl[k].inst;
            abort       = tbl[k].abrt && (c == 0);
            run_cycle();
         end
         chk("tbl_duty", 0, 32'(duty_o[0]), tbl[k].exp_duty);
         chk("tbl_busy", 0, 32'(busy_o[0]), 32'(tbl[k].exp_busy));
      end

      // Abort on the very boundary where an instant jump would land: duty must not move.
      reset = 1'b0; enable = 1'b1; abort = 1'b0;
      cmd_valid = 1'b1; cmd_duty = 6'd30; cmd_instant = 1'b1;
      run_cycle();
      cmd_valid = 1'b0;
      for (int w = 0; w < 200 && m_pos[0] != PERIOD - 1; w++) run_cycle();
      chk("abort_at_tick", 0, 32'(tick_o[0]), 1);
      saved = m_duty[0];
      abort = 1'b1;
      run_cycle();
      abort = 1'b0;
      for (int w = 0; w < 70; w++) run_cycle();
      chk("abort_final_duty", 0, 32'(duty_o[0]), saved);
      chk("abort_final_busy", 0, 32'(busy_o[0]), 0);

      for (int n = 0; n < 20000; n++) begin
         reset       = ($urandom_range(0, 2999) == 0);
         enable      = ($urandom_range(0, 9) != 0);
         abort       = ($urandom_range(0, 199) == 0);
         cmd_valid   = ($urandom_range(0, 14) == 0);
         cmd_instant = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 1) == 1) begin
            cmd_duty = 6'($urandom_range(0, 63));
         end else begin
            d = m_duty[0] + int'($urandom_range(0, 6)) - 3;
            if (d < 0) d = 0;
            if (d > 63) d = 63;
            cmd_duty = 6'(d);
         end
         run_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
